// File: rtl/fake_psx_if.sv
// Serial link between the poller and a PSX-style controller.
// The poller owns psx_clk/cmd/att; the controller returns data and ack.
interface fake_psx_if;
  logic data;
  logic ack;
  logic psx_clk;
  logic cmd;
  logic att;

  modport master (
    input  data,
    input  ack,
    output psx_clk,
    output cmd,
    output att
  );

  modport slave (
    output data,
    output ack,
    input  psx_clk,
    input  cmd,
    input  att
  );
endinterface

// File: rtl/fake_psx.sv
// Free-running PSX controller poller: sends 0x01,0x42,0x00,0x00,0x00 and
// latches the ID and button bytes from each frame whose signature byte is 0x5A.
module fake_psx #(
  parameter int unsigned IDLE_GAP    = 16,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  fake_psx_if.master         bus,
  output logic [7:0]         id,
  output logic [15:0]        buttons,
  output logic               poll_done,
  output logic               poll_err
);

  typedef enum logic [2:0] {
    StIdle,
    StAttSetup,
    StBitLow,
    StBitHigh,
    StAckWait,
    StEnd
  } state_e;

  localparam logic [15:0] IdleLast = 16'(IDLE_GAP - 1);
  localparam logic [15:0] AckLast  = 16'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx1_q, rx1_d;
  logic [7:0]  rx2_q, rx2_d;
  logic [7:0]  rx3_q, rx3_d;
  logic [7:0]  rx4_q, rx4_d;
  logic        timeout_q, timeout_d;
  logic        att_q, att_d;
  logic        psx_clk_q, psx_clk_d;
  logic        cmd_q, cmd_d;
  logic [7:0]  id_q, id_d;
  logic [15:0] buttons_q, buttons_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Command bit to drive for a given byte/bit position of the poll frame.
  function automatic logic tx_bit(input logic [2:0] byte_idx, input logic [2:0] bit_idx);
    logic [7:0] tx_byte;
    case (byte_idx)
      3'd0:    tx_byte = 8'h01;
      3'd1:    tx_byte = 8'h42;
      default: tx_byte = 8'h00;
    endcase
    return tx_byte[bit_idx];
  endfunction

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    ack_cnt_d  = ack_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    rx1_d      = rx1_q;
    rx2_d      = rx2_q;
    rx3_d      = rx3_q;
    rx4_d      = rx4_q;
    timeout_d  = timeout_q;
    att_d      = att_q;
    psx_clk_d  = psx_clk_q;
    cmd_d      = cmd_q;
    id_d       = id_q;
    buttons_d  = buttons_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        att_d     = 1'b1;
        psx_clk_d = 1'b1;
        cmd_d     = 1'b1;
        if (idle_cnt_q == IdleLast) begin
          state_d    = StAttSetup;
          att_d      = 1'b0;
          idle_cnt_d = '0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          timeout_d  = 1'b0;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end

      StAttSetup: begin
        state_d   = StBitLow;
        psx_clk_d = 1'b0;
        cmd_d     = tx_bit(byte_cnt_q, 3'd0);
      end

      StBitLow: begin
        // LSB-first: each new bit enters at the top and walks down.
        shift_d   = {bus.data, shift_q[7:1]};
        psx_clk_d = 1'b1;
        state_d   = StBitHigh;
      end

      StBitHigh: begin
        if (bit_cnt_q != 3'd7) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          psx_clk_d = 1'b0;
          cmd_d     = tx_bit(byte_cnt_q, bit_cnt_q + 3'd1);
          state_d   = StBitLow;
        end else begin
          bit_cnt_d = '0;
          cmd_d     = 1'b1;
          case (byte_cnt_q)
            3'd1:    rx1_d = shift_q;
            3'd2:    rx2_d = shift_q;
            3'd3:    rx3_d = shift_q;
            3'd4:    rx4_d = shift_q;
            default: ;
          endcase
          if (byte_cnt_q == 3'd4) begin
            state_d = StEnd;
          end else begin
            ack_cnt_d = '0;
            state_d   = StAckWait;
          end
        end
      end

      StAckWait: begin
        if (!bus.ack) begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          psx_clk_d  = 1'b0;
          cmd_d      = tx_bit(byte_cnt_q + 3'd1, 3'd0);
          state_d    = StBitLow;
        end else if (ack_cnt_q == AckLast) begin
          timeout_d = 1'b1;
          state_d   = StEnd;
        end else begin
          ack_cnt_d = ack_cnt_q + 16'd1;
        end
      end

      StEnd: begin
        att_d      = 1'b1;
        psx_clk_d  = 1'b1;
        cmd_d      = 1'b1;
        idle_cnt_d = '0;
        state_d    = StIdle;
        if (!timeout_q && rx2_q == 8'h5A) begin
          id_d      = rx1_q;
          buttons_d = {rx4_q, rx3_q};
          done_d    = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idle_cnt_q <= '0;
      ack_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      rx1_q      <= '0;
      rx2_q      <= '0;
      rx3_q      <= '0;
      rx4_q      <= '0;
      timeout_q  <= 1'b0;
      att_q      <= 1'b1;
      psx_clk_q  <= 1'b1;
      cmd_q      <= 1'b1;
      id_q       <= 8'h00;
      buttons_q  <= 16'hFFFF;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      rx1_q      <= rx1_d;
      rx2_q      <= rx2_d;
      rx3_q      <= rx3_d;
      rx4_q      <= rx4_d;
      timeout_q  <= timeout_d;
      att_q      <= att_d;
      psx_clk_q  <= psx_clk_d;
      cmd_q      <= cmd_d;
      id_q       <= id_d;
      buttons_q  <= buttons_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.att     = att_q;
  assign bus.psx_clk = psx_clk_q;
  assign bus.cmd     = cmd_q;
  assign id          = id_q;
  assign buttons     = buttons_q;
  assign poll_done   = done_q;
  assign poll_err    = err_q;

endmodule

// File: tb/tb_fake_psx.sv
// Directed bench for fake_psx with a behavioural controller on the serial link.
module tb_fake_psx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  id;
  logic [15:0] buttons;
  logic        poll_done;
  logic        poll_err;

  fake_psx_if bus ();

  fake_psx #(.IDLE_GAP(16), .ACK_TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .id        (id),
    .buttons   (buttons),
    .poll_done (poll_done),
    .poll_err  (poll_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Controller model configuration
  logic [7:0] resp [5];
  bit         ack_en = 1'b0;

  // Model / monitor state
  int   cyc = 0;
  int   low_cnt = 0, hi_cnt = 0, run = 0, max_run = 0;
  int   frame_lows = 0;
  int   rise_cnt = 0, rise_cyc = 0, fall_cyc = 0;
  int   done_cnt = 0, err_cnt = 0;
  logic prev_att = 1'b1;
  logic [7:0] cur;

  always @(posedge clk) cyc++;

  // Controller drives data during psx_clk low and pulls ack low on the
  // first ACK_WAIT cycle after each of bytes 0..3.
  always @(negedge clk) begin
    if (bus.att !== 1'b0) begin
      if (prev_att === 1'b0) begin
        rise_cnt++;
        rise_cyc   = cyc;
        frame_lows = low_cnt;
      end
      low_cnt  = 0;
      hi_cnt   = 0;
      run      = 0;
      bus.data = 1'b1;
      bus.ack  = 1'b1;
    end else begin
      if (prev_att !== 1'b0) begin
        fall_cyc = cyc;
        max_run  = 0;
      end
      if (bus.psx_clk === 1'b0) begin
        hi_cnt = 0;
        run++;
        if (run > max_run) max_run = run;
        if (low_cnt < 40) begin
          cur      = resp[low_cnt / 8];
          bus.data = cur[low_cnt % 8];
        end else begin
          bus.data = 1'b1;
        end
        low_cnt++;
        bus.ack = 1'b1;
      end else begin
        run = 0;
        hi_cnt++;
        bus.ack = !(ack_en && hi_cnt == 2 && low_cnt > 0 && low_cnt < 40 && low_cnt % 8 == 0);
      end
    end
    if (poll_done === 1'b1) done_cnt++;
    if (poll_err === 1'b1) err_cnt++;
    prev_att = bus.att;
  end

  task automatic set_resp(input logic [7:0] b0, b1, b2, b3, b4, input bit en);
    resp[0] = b0; resp[1] = b1; resp[2] = b2; resp[3] = b3; resp[4] = b4;
    ack_en  = en;
  endtask

  task automatic wait_frame_end(input int budget, input string name);
    int start = rise_cnt;
    int n = 0;
    while (rise_cnt == start && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (rise_cnt == start) begin
      errors++;
      $display("FAIL %s frame_end: not seen within %0d cycles", name, budget);
    end
  endtask

  // Counts rising edges after reset release until att is seen low.
  task automatic edges_to_att_fall(output int k);
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (bus.att === 1'b0) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.att !== 1'b1) begin errors++; $display("FAIL reset_att: got %b want 1", bus.att); end
    checks++; if (bus.psx_clk !== 1'b1) begin errors++; $display("FAIL reset_psx_clk: got %b want 1", bus.psx_clk); end
    checks++; if (bus.cmd !== 1'b1) begin errors++; $display("FAIL reset_cmd: got %b want 1", bus.cmd); end
    checks++; if (id !== 8'h00) begin errors++; $display("FAIL reset_id: got %h want 00", id); end
    checks++; if (buttons !== 16'hFFFF) begin errors++; $display("FAIL reset_buttons: got %h want ffff", buttons); end
    checks++; if (poll_done !== 1'b0 || poll_err !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got done=%b err=%b want 0 0", poll_done, poll_err);
    end
    repeat (2) @(negedge clk);
  endtask

  // Constant-high data/ack: timing of att/psx_clk/cmd, then an ack timeout.
  task automatic test_first_frame;
    int k;
    int d0, e0;
    logic [7:0] exp_cmd;
    set_resp(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    exp_cmd = 8'h01;
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk); rst_n = 1'b1;
    edges_to_att_fall(k);
    checks++; if (k != 16) begin errors++; $display("FAIL first_att_fall: got edge %0d want 16", k); end
    @(posedge clk); #1;
    checks++; if (bus.psx_clk !== 1'b0) begin errors++; $display("FAIL first_psx_low: got %b want 0", bus.psx_clk); end
    checks++; if (bus.cmd !== exp_cmd[0]) begin errors++; $display("FAIL cmd_bit0: got %b want %b", bus.cmd, exp_cmd[0]); end
    for (int b = 1; b < 8; b++) begin
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (bus.psx_clk !== 1'b0 || bus.cmd !== exp_cmd[b]) begin
        errors++;
        $display("FAIL cmd_bit%0d: got psx_clk=%b cmd=%b want 0 %b", b, bus.psx_clk, bus.cmd, exp_cmd[b]);
      end
    end
    wait_frame_end(100, "timeout");
    checks++; if (rise_cyc - fall_cyc != 26) begin
      errors++; $display("FAIL timeout_len: got %0d want 26 cycles att low", rise_cyc - fall_cyc);
    end
    checks++; if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      errors++; $display("FAIL timeout_pulses: got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0);
    end
    checks++; if (id !== 8'h00 || buttons !== 16'hFFFF) begin
      errors++; $display("FAIL timeout_hold: got id=%h buttons=%h want 00 ffff", id, buttons);
    end
  endtask

  task automatic test_good_poll;
    int d0, e0;
    set_resp(8'hFF, 8'h41, 8'h5A, 8'hFE, 8'h7F, 1'b1);
    d0 = done_cnt; e0 = err_cnt;
    wait_frame_end(300, "good");
    checks++; if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      errors++; $display("FAIL good_pulses: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
    end
    checks++; if (id !== 8'h41) begin errors++; $display("FAIL good_id: got %h want 41", id); end
    checks++; if (buttons !== 16'h7FFE) begin errors++; $display("FAIL good_buttons: got %h want 7ffe", buttons); end
    checks++; if (frame_lows != 40) begin errors++; $display("FAIL psx_clk_lows: got %0d want 40", frame_lows); end
    checks++; if (max_run != 1) begin errors++; $display("FAIL psx_clk_low_width: got %0d want 1", max_run); end
  endtask

  task automatic test_bad_signature;
    int d0, e0;
    set_resp(8'hFF, 8'h99, 8'h00, 8'h11, 8'h22, 1'b1);
    d0 = done_cnt; e0 = err_cnt;
    wait_frame_end(300, "badsig");
    checks++; if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      errors++; $display("FAIL badsig_pulses: got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0);
    end
    checks++; if (id !== 8'h41 || buttons !== 16'h7FFE) begin
      errors++; $display("FAIL badsig_hold: got id=%h buttons=%h want 41 7ffe", id, buttons);
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    set_resp(8'hFF, 8'h73, 8'h5A, 8'hCD, 8'hAB, 1'b1);
    d0 = done_cnt;
    wait_frame_end(300, "b2b_a");
    checks++; if (id !== 8'h73 || buttons !== 16'hABCD) begin
      errors++; $display("FAIL b2b_a: got id=%h buttons=%h want 73 abcd", id, buttons);
    end
    set_resp(8'hFF, 8'h12, 8'h5A, 8'h00, 8'h80, 1'b1);
    wait_frame_end(300, "b2b_b");
    checks++; if (id !== 8'h12 || buttons !== 16'h8000) begin
      errors++; $display("FAIL b2b_b: got id=%h buttons=%h want 12 8000", id, buttons);
    end
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_reset_midframe;
    int d0, e0, k, n;
    set_resp(8'hFF, 8'h5C, 8'h5A, 8'h34, 8'h12, 1'b1);
    d0 = done_cnt; e0 = err_cnt;
    n = 0;
    while (low_cnt < 20 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    checks++; if (low_cnt < 20) begin errors++; $display("FAIL midframe_reach: got low_cnt=%0d want >=20", low_cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.att !== 1'b1 || bus.psx_clk !== 1'b1 || bus.cmd !== 1'b1) begin
      errors++; $display("FAIL midreset_lines: got att=%b psx_clk=%b cmd=%b want 1 1 1", bus.att, bus.psx_clk, bus.cmd);
    end
    checks++; if (id !== 8'h00 || buttons !== 16'hFFFF) begin
      errors++; $display("FAIL midreset_outputs: got id=%h buttons=%h want 00 ffff", id, buttons);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (done_cnt != d0 || err_cnt != e0) begin
      errors++; $display("FAIL midreset_pulses: got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0);
    end
    @(negedge clk); rst_n = 1'b1;
    edges_to_att_fall(k);
    checks++; if (k != 16) begin errors++; $display("FAIL midreset_att_fall: got edge %0d want 16", k); end
    wait_frame_end(300, "after_reset");
    checks++; if (id !== 8'h5C || buttons !== 16'h1234 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL after_reset_poll: got id=%h buttons=%h done=%0d want 5c 1234 1", id, buttons, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset;
    test_first_frame;
    test_good_poll;
    test_bad_signature;
    test_back_to_back;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/fake_psx.md
FAKE_PSX -- requirements
Module: fake_psx

Interface
REQ-001 Parameter IDLE_GAP, default 16, clk cycles with att high between polls (min 2).
REQ-002 Parameter ACK_TIMEOUT, default 8, max clk cycles to wait for ack low after a byte.
REQ-003 clk  input  1  sole clock, rising-edge active; all logic in this domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 data  input  1  serial data from controller, LSB first.
REQ-006 ack  input  1  controller acknowledge, active-low, idle high.
REQ-007 psx_clk  output  1  serial clock to controller, idle high.
REQ-008 cmd  output  1  serial command to controller, LSB first, idle high.
REQ-009 att  output  1  attention/select, active-low, idle high.
REQ-010 id  output  8  controller ID byte from last good poll.
REQ-011 buttons  output  16  {rx byte4, rx byte3} from last good poll, raw active-low.
REQ-012 poll_done  output  1  one-cycle pulse on successful poll completion.
REQ-013 poll_err  output  1  one-cycle pulse on aborted/invalid poll.

Function
REQ-014 SHALL be a registered FSM with states IDLE, ATT_SETUP, BIT_LOW, BIT_HIGH, ACK_WAIT, END; all outputs registered.
REQ-015 Poll frame SHALL transmit 5 bytes 0x01, 0x42, 0x00, 0x00, 0x00 and receive 5 bytes rx0..rx4.
REQ-016 IDLE: att=1, psx_clk=1, cmd=1; counter runs IDLE_GAP cycles, then on that edge -> ATT_SETUP with att=0.
REQ-017 ATT_SETUP SHALL last exactly 1 cycle (att low, psx_clk high), then -> BIT_LOW for bit 0 of byte 0.
REQ-018 BIT_LOW: psx_clk=0 and cmd=current tx bit, both set on the edge entering BIT_LOW; lasts 1 cycle.
REQ-019 On the edge leaving BIT_LOW, data SHALL be shifted into rx register at MSB (LSB-first assembly) and psx_clk set to 1 (BIT_HIGH); BIT_HIGH lasts 1 cycle.
REQ-020 Each bit SHALL take exactly 2 clk cycles; a byte 16 cycles; bit counter wraps 7->0 at byte end.
REQ-021 After bytes 0..3, BIT_HIGH of bit 7 -> ACK_WAIT (psx_clk=1, cmd=1); after byte 4 -> END.
REQ-022 ACK_WAIT: ack sampled each rising edge; ack==0 -> BIT_LOW of next byte on that edge; after ACK_TIMEOUT cycles without ack==0 -> END with error flag.
REQ-023 END: lasts 1 cycle with att still low, then att=1, psx_clk=1, cmd=1, -> IDLE with idle counter cleared.
REQ-024 Success: no timeout and rx2==0x5A; on leaving END SHALL load id<=rx1, buttons<={rx4,rx3}, pulse poll_done.
REQ-025 Failure (timeout or rx2!=0x5A): id/buttons hold previous values; poll_err pulses on leaving END; poll_done stays 0.
REQ-026 ack low outside ACK_WAIT SHALL be ignored; data outside BIT_LOW SHALL be ignored.
REQ-027 Polling SHALL repeat indefinitely with no external trigger.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, att=1, psx_clk=1, cmd=1, id=0x00, buttons=0xFFFF, poll_done=0, poll_err=0, all counters/shift registers 0.
REQ-029 Reset mid-frame SHALL abort the frame with no poll_done/poll_err pulse; after release, first att fall occurs IDLE_GAP cycles later.

Verification
REQ-030 Release rst_n, data=1, ack=1 constant -> att falls on 16th rising edge; psx_clk first low next edge; cmd bits of byte 0 = 1,0,0,0,0,0,0,0.
REQ-031 Controller model returns 0xFF,0x41,0x5A,0xFE,0x7F with ack low 1 cycle after bytes 0..3 -> poll_done pulse, id=0x41, buttons=0x7FFE.
REQ-032 ack held high -> after byte 0 plus 8 cycles END, att high, poll_err pulse, id=0x00, buttons=0xFFFF unchanged.
REQ-033 Valid model but rx2=0x00 -> poll_err, outputs keep previous good values.
REQ-034 Assert rst_n low during byte 2 -> att, psx_clk, cmd high immediately; no pulses; next att fall 16 cycles after release.
REQ-035 Count psx_clk low pulses per frame -> exactly 40, each 1 cycle low, 1+ cycle high.
